// File: rtl/bloom_match_stats.sv
// rtl/bloom_match_stats.sv - per-engine, per-string-length Bloom match counters with CSR snapshot
//
// Ports:
//   clk_i, srst_i               main clock, synchronous active-high reset
//   en_i                        counting enable; strobes ignored while low
//   match_stb_i[CNT_NUM]        one-cycle hit pulses, bit = e*LEN_CNT + (len - MIN_STR_SIZE)
//   amm_slave_csr_*             Avalon-MM CSR slave, no wait states, read latency 1
//     addr 0       CTRL   wr: bit0 snapshot, bit1 clear_all, bit2 cos / rd: {cos, 2'b00}
//     addr 1       STATUS rd: bit0 sticky overflow
//     addr 2+i     shadow counter i (zero-extended)
//     addr >= 2+CNT_NUM reads 0
module bloom_match_stats #(
    parameter int ENGINES_CNT    = 8,
    parameter int MIN_STR_SIZE   = 3,
    parameter int MAX_STR_SIZE   = 5,
    parameter int CNT_W          = 16,
    parameter bit SATURATE       = 1'b1,
    parameter int AMM_CSR_ADDR_W = 12,
    parameter int AMM_CSR_DATA_W = 16
) (
    input  logic                                            clk_i,
    input  logic                                            srst_i,
    input  logic                                            en_i,
    input  logic [ENGINES_CNT*(MAX_STR_SIZE-MIN_STR_SIZE+1)-1:0] match_stb_i,
    input  logic [AMM_CSR_ADDR_W-1:0]                       amm_slave_csr_address_i,
    input  logic                                            amm_slave_csr_read_i,
    output logic [AMM_CSR_DATA_W-1:0]                       amm_slave_csr_readdata_o,
    input  logic                                            amm_slave_csr_write_i,
    input  logic [AMM_CSR_DATA_W-1:0]                       amm_slave_csr_writedata_i
);

    localparam int LEN_CNT = MAX_STR_SIZE - MIN_STR_SIZE + 1;
    localparam int CNT_NUM = ENGINES_CNT * LEN_CNT;

    logic [CNT_W-1:0]          live   [CNT_NUM];
    logic [CNT_W-1:0]          shadow [CNT_NUM];
    logic                      ovf;
    logic                      cos;
    logic                      ctrl_wr;
    logic                      snap;
    logic                      clr;
    logic [31:0]               addr_ext;
    logic [AMM_CSR_DATA_W-1:0] rd_val;
    logic                      unused_wdata;

    assign ctrl_wr      = amm_slave_csr_write_i && (amm_slave_csr_address_i == '0);
    assign snap         = ctrl_wr && amm_slave_csr_writedata_i[0];
    assign clr          = ctrl_wr && amm_slave_csr_writedata_i[1];
    assign addr_ext     = 32'(amm_slave_csr_address_i);
    assign unused_wdata = ^amm_slave_csr_writedata_i[AMM_CSR_DATA_W-1:3];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < CNT_NUM; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
            ovf <= 1'b0;
            cos <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                cos <= amm_slave_csr_writedata_i[2];
            end
            if (clr) begin
                // clear_all wins over snapshot and drops this cycle's strobes
                for (int i = 0; i < CNT_NUM; i++) begin
                    live[i]   <= '0;
                    shadow[i] <= '0;
                end
                ovf <= 1'b0;
            end else begin
                for (int i = 0; i < CNT_NUM; i++) begin
                    if (snap) begin
                        shadow[i] <= live[i];
                    end
                    if (snap && cos) begin
                        // new window starts here; a strobe in this cycle is its first hit
                        live[i] <= (en_i && match_stb_i[i]) ? CNT_W'(1) : '0;
                    end else if (en_i && match_stb_i[i]) begin
                        if (&live[i]) begin
                            ovf <= 1'b1;
                            if (!SATURATE) begin
                                live[i] <= '0;
                            end
                        end else begin
                            live[i] <= live[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (addr_ext == 32'd0) begin
            rd_val[2] = cos;
        end else if (addr_ext == 32'd1) begin
            rd_val[0] = ovf;
        end else begin
            for (int i = 0; i < CNT_NUM; i++) begin
                if (addr_ext == 32'(i + 2)) begin
                    rd_val[CNT_W-1:0] = shadow[i];
                end
            end
        end
    end

    // Registered read path: a same-cycle write is seen only by later reads
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            amm_slave_csr_readdata_o <= '0;
        end else if (amm_slave_csr_read_i) begin
            amm_slave_csr_readdata_o <= rd_val;
        end
    end

endmodule

// File: tb/tb_bloom_match_stats.sv
// tb/tb_bloom_match_stats.sv - randomized self-checking bench for bloom_match_stats
module tb_bloom_match_stats;

    localparam int N    = 24;
    localparam int MAXV = 15;

    logic          clk = 1'b0;
    logic          srst;
    logic          en;
    logic [N-1:0]  stb;
    logic [11:0]   addr;
    logic          rd;
    logic          wr;
    logic [15:0]   wdata;
    logic [15:0]   rdata_sat;
    logic [15:0]   rdata_wrap;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    always #5 clk = ~clk;

    bloom_match_stats #(
        .ENGINES_CNT(8), .MIN_STR_SIZE(3), .MAX_STR_SIZE(5), .CNT_W(4), .SATURATE(1'b1),
        .AMM_CSR_ADDR_W(12), .AMM_CSR_DATA_W(16)
    ) dut_sat (
        .clk_i(clk), .srst_i(srst), .en_i(en), .match_stb_i(stb),
        .amm_slave_csr_address_i(addr), .amm_slave_csr_read_i(rd),
        .amm_slave_csr_readdata_o(rdata_sat), .amm_slave_csr_write_i(wr),
        .amm_slave_csr_writedata_i(wdata)
    );

    bloom_match_stats #(
        .ENGINES_CNT(8), .MIN_STR_SIZE(3), .MAX_STR_SIZE(5), .CNT_W(4), .SATURATE(1'b0),
        .AMM_CSR_ADDR_W(12), .AMM_CSR_DATA_W(16)
    ) dut_wrap (
        .clk_i(clk), .srst_i(srst), .en_i(en), .match_stb_i(stb),
        .amm_slave_csr_address_i(addr), .amm_slave_csr_read_i(rd),
        .amm_slave_csr_readdata_o(rdata_wrap), .amm_slave_csr_write_i(wr),
        .amm_slave_csr_writedata_i(wdata)
    );

    // Reference model: index 0 = saturating unit, index 1 = wrapping unit
    int          m_live [2][N];
    int          m_shd  [2][N];
    bit          m_ovf  [2];
    bit          m_cos;
    logic [15:0] m_rd   [2];

    function automatic logic [15:0] model_read(int s, logic [11:0] a);
        if (a == 12'd0) return m_cos ? 16'd4 : 16'd0;
        if (a == 12'd1) return m_ovf[s] ? 16'd1 : 16'd0;
        if (int'(a) >= 2 && int'(a) < 2 + N) return 16'(m_shd[s][int'(a) - 2]);
        return 16'd0;
    endfunction

    always @(posedge clk) begin : model
        bit snap, clr, hit;
        if (srst) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < N; i++) begin
                    m_live[s][i] = 0;
                    m_shd[s][i]  = 0;
                end
                m_ovf[s] = 1'b0;
                m_rd[s]  = 16'd0;
            end
            m_cos = 1'b0;
        end else begin
            if (rd) begin
                m_rd[0] = model_read(0, addr);
                m_rd[1] = model_read(1, addr);
            end
            snap = wr && addr == 12'd0 && wdata[0];
            clr  = wr && addr == 12'd0 && wdata[1];
            for (int s = 0; s < 2; s++) begin
                if (clr) begin
                    for (int i = 0; i < N; i++) begin
                        m_live[s][i] = 0;
                        m_shd[s][i]  = 0;
                    end
                    m_ovf[s] = 1'b0;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        hit = en && stb[i];
                        if (snap) m_shd[s][i] = m_live[s][i];
                        if (snap && m_cos) begin
                            m_live[s][i] = hit ? 1 : 0;
                        end else if (hit) begin
                            if (m_live[s][i] == MAXV) begin
                                m_ovf[s] = 1'b1;
                                m_live[s][i] = (s == 0) ? MAXV : 0;
                            end else begin
                                m_live[s][i] = m_live[s][i] + 1;
                            end
                        end
                    end
                end
            end
            if (wr && addr == 12'd0) m_cos = wdata[2];
        end
    end

    task automatic check(string nm, logic [15:0] got, logic [15:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_sat", rdata_sat, m_rd[0]);
            check("model_wrap", rdata_wrap, m_rd[1]);
        end
    end

    task automatic drive(logic r, logic w, logic [11:0] a, logic [15:0] d, logic [N-1:0] s);
        @(negedge clk);
        rd = r; wr = w; addr = a; wdata = d; stb = s;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 12'd0, 16'd0, '0);
    endtask

    task automatic ctrl(logic [15:0] d);
        drive(1'b0, 1'b1, 12'd0, d, '0);
    endtask

    task automatic pulse(int b, int n);
        logic [N-1:0] one;
        one = 1;
        repeat (n) drive(1'b0, 1'b0, 12'd0, 16'd0, one << b);
    endtask

    task automatic rd_chk(string nm, logic [11:0] a, logic [15:0] es, logic [15:0] ew);
        drive(1'b1, 1'b0, a, 16'd0, '0);
        idle();
        check({nm, "_sat"}, rdata_sat, es);
        check({nm, "_wrap"}, rdata_wrap, ew);
    endtask

    initial begin
        logic [N-1:0] one;
        one  = 1;
        srst = 1'b1; en = 1'b0; stb = '0; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_rd_sat", rdata_sat, 16'd0);
        check("reset_rd_wrap", rdata_wrap, 16'd0);
        srst   = 1'b0;
        chk_en = 1'b1;
        idle();
        check("pre_read_sat", rdata_sat, 16'd0);
        rd_chk("rst_ctrl", 12'd0, 16'd0, 16'd0);
        rd_chk("rst_status", 12'd1, 16'd0, 16'd0);
        rd_chk("rst_shd0", 12'd2, 16'd0, 16'd0);
        rd_chk("rst_shd23", 12'd25, 16'd0, 16'd0);

        en = 1'b1;
        pulse(0, 5);
        pulse(23, 3);
        ctrl(16'h1);
        rd_chk("snap_shd0", 12'd2, 16'd5, 16'd5);
        rd_chk("snap_shd23", 12'd25, 16'd3, 16'd3);
        rd_chk("snap_shd1", 12'd3, 16'd0, 16'd0);

        ctrl(16'h4);
        pulse(4, 6);
        drive(1'b0, 1'b1, 12'd0, 16'h5, one << 4);
        rd_chk("cos_shd4", 12'd6, 16'd6, 16'd6);
        ctrl(16'h5);
        rd_chk("cos_carry", 12'd6, 16'd1, 16'd1);
        rd_chk("cos_ctrl", 12'd0, 16'd4, 16'd4);

        pulse(1, 20);
        ctrl(16'h5);
        rd_chk("ovf20_shd1", 12'd3, 16'd15, 16'd4);
        rd_chk("ovf20_status", 12'd1, 16'd1, 16'd1);
        ctrl(16'h6);
        pulse(1, 17);
        ctrl(16'h5);
        rd_chk("ovf17_shd1", 12'd3, 16'd15, 16'd1);
        rd_chk("ovf17_status", 12'd1, 16'd1, 16'd1);

        pulse(1, 2);
        en = 1'b0;
        pulse(1, 10);
        en = 1'b1;
        ctrl(16'h5);
        rd_chk("en_low", 12'd3, 16'd2, 16'd2);
        drive(1'b0, 1'b1, 12'd0, 16'h3, one << 1);
        rd_chk("clr_shd1", 12'd3, 16'd0, 16'd0);
        rd_chk("clr_shd23", 12'd25, 16'd0, 16'd0);
        rd_chk("clr_status", 12'd1, 16'd0, 16'd0);
        rd_chk("clr_ctrl", 12'd0, 16'd0, 16'd0);
        ctrl(16'h1);
        rd_chk("clr_drop", 12'd3, 16'd0, 16'd0);

        ctrl(16'h4);
        pulse(1, 3);
        drive(1'b1, 1'b0, 12'd0, 16'd0, one << 1);
        srst = 1'b1;
        idle();
        check("srst_rd_sat", rdata_sat, 16'd0);
        check("srst_rd_wrap", rdata_wrap, 16'd0);
        srst = 1'b0;
        rd_chk("srst_ctrl", 12'd0, 16'd0, 16'd0);
        ctrl(16'h1);
        rd_chk("srst_live", 12'd3, 16'd0, 16'd0);

        for (int c = 0; c < 3000; c++) begin
            logic          r, w;
            logic [11:0]   a;
            logic [15:0]   d;
            r = ($urandom_range(0, 2) == 0);
            w = ($urandom_range(0, 7) == 0);
            a = 12'($urandom_range(0, 27));
            if (w && $urandom_range(0, 3) != 0) a = 12'd0;
            d = 16'($urandom);
            d[1] = ($urandom_range(0, 15) == 0);
            en = ($urandom_range(0, 7) != 0);
            drive(r, w, a, d, N'($urandom & $urandom & $urandom));
        end
        idle();
        idle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bloom_match_stats.md
Name: bloom_match_stats

Overview:
- Per-engine, per-string-length match statistics unit for the Bloom filter search path.
- Counts suspect-string hits from every bloom_search_engine output, for every string length MIN_STR_SIZE..MAX_STR_SIZE.
- Counters are exposed through an Avalon-MM CSR slave with atomic snapshot, clear-on-snapshot and a sticky overflow flag.
- Sits in the main clock domain beside bloom_filter_csr; it is the generalised replacement for the fixed matches_cnt path.

Parameters:
- ENGINES_CNT, 8: number of search engines (= AST_SINK_SYMBOLS); >= 1.
- MIN_STR_SIZE, 3: shortest string length counted; >= 1.
- MAX_STR_SIZE, 5: longest string length counted; >= MIN_STR_SIZE.
- CNT_W, 16: live/shadow counter width; 1 <= CNT_W <= AMM_CSR_DATA_W.
- SATURATE, 1: 1 = counters stick at all-ones; 0 = counters wrap to 0.
- AMM_CSR_ADDR_W, 12: CSR word address width; 2 + ENGINES_CNT*LEN_CNT <= 2**AMM_CSR_ADDR_W.
- AMM_CSR_DATA_W, 16: CSR data width; >= 3.
- LEN_CNT (derived): MAX_STR_SIZE - MIN_STR_SIZE + 1.
- CNT_NUM (derived): ENGINES_CNT * LEN_CNT.

Ports:
- clk_i  in  1  main clock.
- srst_i  in  1  synchronous reset, active-high.
- en_i  in  1  counting enable; strobes are ignored while low.
- match_stb_i  in  CNT_NUM  one-cycle hit pulses; bit index = e*LEN_CNT + (len - MIN_STR_SIZE).
- amm_slave_csr_address_i  in  AMM_CSR_ADDR_W  word address.
- amm_slave_csr_read_i  in  1  read request.
- amm_slave_csr_readdata_o  out  AMM_CSR_DATA_W  read data, latency 1.
- amm_slave_csr_write_i  in  1  write request.
- amm_slave_csr_writedata_i  in  AMM_CSR_DATA_W  write data.

Behaviour:
- Reset: all live counters, shadow counters, the ovf flag, the cos bit and readdata_o are 0. Reset is synchronous and active-high, and aborts any operation in progress.
- Live counter i, per cycle, when en_i & match_stb_i[i]:
  - not at all-ones: +1;
  - at all-ones: holds if SATURATE=1, becomes 0 if SATURATE=0;
  - in both all-ones cases ovf is set to 1 (sticky).
- Register map:
  - addr 0 CTRL (write): bit0 = snapshot, bit1 = clear_all, bit2 = cos (clear-on-snapshot, stored).
  - addr 0 CTRL (read): returns {0.., cos, 2'b00}.
  - addr 1 STATUS (read-only): bit0 = ovf; other bits 0.
  - addr 2+i (read-only): shadow counter i, zero-extended to AMM_CSR_DATA_W.
  - Addresses >= 2+CNT_NUM read 0. Writes to any address other than 0 are ignored.
- Snapshot, on the cycle of a CTRL write with bit0=1:
  - every shadow counter takes the current live value (the pre-increment value of that cycle), all in one clock;
  - if cos=1 (value stored before this write), each live counter becomes 1 if it has a qualified strobe that cycle, else 0;
  - if cos=0, live counters count normally.
- clear_all (bit1=1): live counters, shadow counters and ovf become 0. Strobes in that cycle are discarded. clear_all has priority over snapshot when both bits are set in one write.
- Read: readdata_o is registered and valid on the cycle after read_i; it holds its value when no read is issued.
  - Reading STATUS or shadow counters has no side effects.
  - If read and write are asserted in the same cycle, the write takes effect and the read returns pre-write contents.
- No wait states. The slave accepts one access per cycle.

Test Plan:
- Reset, then read addrs 0, 1, 2, 25 (defaults: CNT_NUM=24) -> all return 0; readdata is 0 before the first read.
- en_i=1; pulse bit 0 ×5 and bit 23 ×3; write CTRL=0x1; read addr 2 and addr 25 -> 5 and 3; other counters 0; the value appears 1 cycle after read_i.
- Write CTRL=0x4 (cos); pulse bit 4 ×7 with one pulse in the snapshot cycle; write CTRL=0x5; read addr 6 -> 6. Write CTRL=0x5 again; read addr 6 -> 1.
- SATURATE=1, CNT_W=4: 20 pulses on bit 1, snapshot -> addr 3 reads 15, STATUS reads 1. SATURATE=0: 17 pulses -> reads 1, STATUS reads 1.
- en_i=0 during 10 pulses -> counts unchanged. Write CTRL=0x3 with a coincident pulse -> all shadows read 0, STATUS reads 0, and the next snapshot of that counter reads 0.
- Assert srst_i mid-count with cos=1 -> all counters 0, CTRL reads 0, readdata_o is 0 on the following cycle.
